// File: rtl/myproject_dense_acc_pkg.sv
// Shared types and helpers for the dense-layer accumulator.
// Holds the FSM state encoding, counter width helper and the saturating narrow function.
package myproject_dense_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int SAT_W = 64;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a sign-extended value to a signed 'width'-bit range, or pass it through for wrap.
    function automatic logic signed [SAT_W-1:0] sat_narrow(
        input logic signed [SAT_W-1:0] value,
        input int                      width,
        input bit                      saturate
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (!saturate)          return value;
        else if (value > max_v) return max_v;
        else if (value < min_v) return min_v;
        else                    return value;
    endfunction

endpackage

// File: rtl/myproject_requant.sv
// Requantiser: arithmetic right shift (floor) followed by saturate or wrap to OUT_W.
module myproject_requant
    import myproject_dense_acc_pkg::*;
#(
    parameter int ACC_W    = 23,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 2,
    parameter int SATURATE = 1
) (
    input  logic signed [ACC_W-1:0] din,
    output logic signed [OUT_W-1:0] dout
);

    logic signed [ACC_W-1:0] shifted;
    logic signed [SAT_W-1:0] wide;

    always_comb begin
        shifted = din >>> SHIFT;
        wide    = {{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted};
        // Low OUT_W bits are the wrapped result when saturation is disabled.
        dout    = OUT_W'(sat_narrow(wide, OUT_W, SATURATE != 0));
    end

endmodule

// File: rtl/myproject_dense_acc.sv
// Dense-layer accumulator: sums N_TERMS products plus a bias per neuron and emits
// the requantised result on a registered valid/ready port with a vector-last flag.
module myproject_dense_acc
    import myproject_dense_acc_pkg::*;
#(
    parameter int  PROD_W   = 18,
    parameter int  BIAS_W   = 18,
    parameter int  N_TERMS  = 16,
    parameter int  N_OUT    = 8,
    parameter int  OUT_W    = 16,
    parameter int  SHIFT    = 2,
    parameter int  SATURATE = 1,
    localparam int ACC_W    = PROD_W + $clog2(N_TERMS) + 1,
    localparam int IDX_W    = cnt_w(N_OUT)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [BIAS_W-1:0] bias_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_idx
);

    localparam int TERM_W = cnt_w(N_TERMS);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // the producer holds data stable while valid & !ready.

    state_e            state_q, state_d;
    logic [TERM_W-1:0] term_cnt_q, term_cnt_d;
    logic [IDX_W-1:0]  neuron_cnt_q, neuron_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;

    logic              accept;
    logic              last_term;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W-1:0]  acc_next;
    logic [OUT_W-1:0]  rq_data;

    assign prod_ready = (state_q == ACC) || (state_q == HOLD && out_ready);
    assign accept     = prod_valid && prod_ready;
    assign last_term  = (term_cnt_q == TERM_W'(N_TERMS - 1));

    // First term of a neuron seeds the sum with its bias instead of the old total.
    assign acc_base = (term_cnt_q == '0) ? {{(ACC_W-BIAS_W){bias_in[BIAS_W-1]}}, bias_in} : acc_q;
    assign acc_next = acc_base + {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};

    myproject_requant #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .SATURATE(SATURATE)
    ) u_requant (
        .din (acc_next),
        .dout(rq_data)
    );

    always_comb begin
        state_d      = state_q;
        term_cnt_d   = term_cnt_q;
        neuron_cnt_d = neuron_cnt_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_idx_d    = out_idx_q;

        if (state_q == HOLD && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
        end

        if (accept) begin
            acc_d = acc_next;
            if (last_term) begin
                term_cnt_d   = '0;
                out_data_d   = rq_data;
                out_idx_d    = neuron_cnt_q;
                out_last_d   = (neuron_cnt_q == IDX_W'(N_OUT - 1));
                neuron_cnt_d = (neuron_cnt_q == IDX_W'(N_OUT - 1)) ? '0 : neuron_cnt_q + 1'b1;
                out_valid_d  = 1'b1;
                state_d      = HOLD;
            end else begin
                term_cnt_d = term_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= ACC;
            term_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            term_cnt_q   <= term_cnt_d;
            neuron_cnt_q <= neuron_cnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_idx_q    <= out_idx_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Bench for myproject_dense_acc: a saturating and a wrapping instance share one stimulus
// stream; a cycle model pushes expected results to a queue that is checked at the output.
module tb_myproject_dense_acc;

    localparam int PROD_W  = 18;
    localparam int BIAS_W  = 18;
    localparam int N_TERMS = 16;
    localparam int N_OUT   = 8;
    localparam int OUT_W   = 16;
    localparam int IDX_W   = 3;
    localparam int SHIFT   = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic [PROD_W-1:0] prod_data;
    logic              prod_valid;
    logic              prod_ready;
    logic [BIAS_W-1:0] bias_in;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IDX_W-1:0]  out_idx;

    logic              w_prod_ready;
    logic [OUT_W-1:0]  w_out_data;
    logic              w_out_valid;
    logic              w_out_last;
    logic [IDX_W-1:0]  w_out_idx;

    always #5 ap_clk = ~ap_clk;

    myproject_dense_acc u_dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .prod_data (prod_data),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .bias_in   (bias_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx)
    );

    myproject_dense_acc #(.SATURATE(0)) u_dut_wrap (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .prod_data (prod_data),
        .prod_valid(prod_valid),
        .prod_ready(w_prod_ready),
        .bias_in   (bias_in),
        .out_data  (w_out_data),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_last  (w_out_last),
        .out_idx   (w_out_idx)
    );

    typedef struct packed {
        logic [OUT_W-1:0] sat_v;
        logic [OUT_W-1:0] wrap_v;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    exp_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     rand_ready_en = 1'b0;

    int     m_term  = 0;
    longint m_sum   = 0;
    bit     m_valid = 1'b0;
    int     m_idx   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input longint s, input int idx);
        exp_t        e;
        longint      y;
        longint      c;
        logic [63:0] yb;
        y  = s >>> SHIFT;
        c  = (y > 32767) ? 32767 : ((y < -32768) ? -32768 : y);
        yb = y;
        e.sat_v  = OUT_W'(c);
        e.wrap_v = yb[OUT_W-1:0];
        e.idx    = IDX_W'(idx);
        e.last   = (idx == N_OUT - 1);
        return e;
    endfunction

    // Reference model and scoreboard, sampled on the falling edge.
    initial begin
        forever begin
            bit     m_rdy;
            exp_t   e;
            longint d;
            @(negedge ap_clk);
            if (ap_rst) begin
                m_term  = 0;
                m_sum   = 0;
                m_valid = 1'b0;
                m_idx   = 0;
                exp_q.delete();
            end else begin
                m_rdy = !m_valid || out_ready;
                check("prod_ready", prod_ready, m_rdy);
                check("prod_ready_wrap", w_prod_ready, m_rdy);
                check("out_valid", out_valid, m_valid);
                check("out_valid_wrap", w_out_valid, m_valid);
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        check("queue_underflow", 1, 0);
                    end else begin
                        e = exp_q[0];
                        check("out_data_sat", out_data, e.sat_v);
                        check("out_data_wrap", w_out_data, e.wrap_v);
                        check("out_idx", out_idx, e.idx);
                        check("out_idx_wrap", w_out_idx, e.idx);
                        check("out_last", out_last, e.last);
                        check("out_last_wrap", w_out_last, e.last);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                    if (out_ready) m_valid = 1'b0;
                end
                if (prod_valid && m_rdy) begin
                    d = longint'($signed(prod_data));
                    if (m_term == 0) m_sum = longint'($signed(bias_in)) + d;
                    else             m_sum = m_sum + d;
                    m_term++;
                    if (m_term == N_TERMS) begin
                        m_term = 0;
                        exp_q.push_back(make_exp(m_sum, m_idx));
                        m_valid = 1'b1;
                        m_idx   = (m_idx + 1) % N_OUT;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offers n products; bias_in carries the real bias only on the first one.
    task automatic drive_neuron(input int bias, input bit rnd, input int val, input int n);
        int guard;
        @(posedge ap_clk);
        #1;
        for (int k = 0; k < n; k++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                prod_valid = 1'b0;
                @(posedge ap_clk);
                #1;
            end
            prod_valid = 1'b1;
            prod_data  = rnd ? PROD_W'($urandom_range(0, 262143)) : PROD_W'(val);
            bias_in    = (k == 0) ? BIAS_W'(bias) : BIAS_W'($urandom_range(0, 262143));
            guard = 0;
            @(negedge ap_clk);
            while (!prod_ready && guard < 100) begin
                @(negedge ap_clk);
                guard++;
            end
            check("accept_timeout", (guard >= 100), 0);
            @(posedge ap_clk);
            #1;
        end
        prod_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        prod_valid = 1'b0;
        prod_data  = '0;
        bias_in    = '0;
        out_ready  = 1'b0;
        ap_rst     = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        out_ready = 1'b1;
        @(posedge ap_clk);
        #3 ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_release_prod_ready", prod_ready, 1);

        // bias 10 + 16*4 = 74 -> 18
        drive_neuron(10, 1'b0, 4, N_TERMS);
        wait_drain();
        // 16 * min product -> -524288: saturates to -32768, wraps to 0
        drive_neuron(0, 1'b0, -131072, N_TERMS);
        wait_drain();
        // sum -5 -> floor(-5/4) = -2
        drive_neuron(-5, 1'b0, 0, N_TERMS);
        wait_drain();

        // Backpressure then same-cycle handoff into the next neuron.
        @(posedge ap_clk);
        #1 out_ready = 1'b0;
        drive_neuron(1234, 1'b1, 0, N_TERMS);
        fork
            begin
                repeat (6) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join_none
        drive_neuron(-777, 1'b1, 0, N_TERMS);
        wait_drain();

        // Random data with random consumer stalls; indices wrap past N_OUT-1.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b = int'($urandom_range(0, 262143)) - 131072;
            drive_neuron(b, 1'b1, 0, N_TERMS);
        end
        @(posedge ap_clk);
        #1;
        rand_ready_en = 1'b0;
        out_ready     = 1'b1;
        wait_drain();

        // Asynchronous reset part-way through a neuron.
        drive_neuron(55, 1'b1, 0, 9);
        #2 ap_rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_idx", out_idx, 0);
        check("midrst_out_last", out_last, 0);
        repeat (2) @(posedge ap_clk);
        #3 ap_rst = 1'b0;
        drive_neuron(100, 1'b1, 0, N_TERMS);
        wait_drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
